// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions for the EX/MEM stage: branch funct3 codes and the
// stage FSM state encoding.
package riscv_pkg;

    localparam logic [2:0] BEQ  = 3'b000;
    localparam logic [2:0] BNE  = 3'b001;
    localparam logic [2:0] BLT  = 3'b100;
    localparam logic [2:0] BGE  = 3'b101;
    localparam logic [2:0] BLTU = 3'b110;
    localparam logic [2:0] BGEU = 3'b111;

    typedef enum logic [0:0] {
        NORMAL = 1'b0,
        SQUASH = 1'b1
    } ex_state_e;

    // JALR targets drop bit 0 of the computed address.
    function automatic logic [31:0] jalr_target(input logic [31:0] sum);
        return {sum[31:1], 1'b0};
    endfunction

endpackage

// File: rtl/unidade_branch.sv
// Combinational branch condition evaluation from funct3 and the ALU status flags.
module unidade_branch
    import riscv_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       zero,
    input  logic       less,
    input  logic       less_unsigned,
    output logic       condition
);

    always_comb begin
        condition = 1'b0;
        case (funct3)
            BEQ:     condition = zero;
            BNE:     condition = ~zero;
            BLT:     condition = less;
            BGE:     condition = ~less;
            BLTU:    condition = less_unsigned;
            BGEU:    condition = ~less_unsigned;
            default: condition = 1'b0;
        endcase
    end

endmodule

// File: rtl/estagio_ex_mem.sv
// EX/MEM pipeline register with branch/jump resolution, one-cycle fetch redirect
// and wrong-path squash. Define MISALIGN_TRAP_EN to trap on targets with bit 1 set.
module estagio_ex_mem
    import riscv_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] alu_result,
    input  logic        zero,
    input  logic        less,
    input  logic        less_unsigned,
    input  logic [31:0] pc_in,
    input  logic [31:0] imm_in,
    input  logic [31:0] rs2_in,
    input  logic [4:0]  rd_in,
    input  logic [2:0]  funct3_in,
    input  logic        valid_in,
    input  logic        branch_in,
    input  logic        jal_in,
    input  logic        jalr_in,
    input  logic        reg_write_in,
    input  logic        mem_read_in,
    input  logic        mem_write_in,
    input  logic        stall,
    input  logic        flush,
    output logic        valid_out,
    output logic        reg_write_out,
    output logic        mem_read_out,
    output logic        mem_write_out,
    output logic [31:0] result_out,
    output logic [31:0] rs2_out,
    output logic [4:0]  rd_out,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic        misaligned_trap
);

    ex_state_e   state_reg;
    ex_state_e   state_next;
    logic        condition;
    logic        taken;
    logic        misaligned;
    logic        squashing;
    logic        keep;
    logic        redirect_take;
    logic [31:0] target;
    logic [31:0] link;

    unidade_branch u_branch (
        .funct3        (funct3_in),
        .zero          (zero),
        .less          (less),
        .less_unsigned (less_unsigned),
        .condition     (condition)
    );

    assign taken  = valid_in & (jal_in | jalr_in | (branch_in & condition));
    assign target = jalr_in ? jalr_target(alu_result) : pc_in + imm_in;
    assign link   = pc_in + 32'd4;

`ifdef MISALIGN_TRAP_EN
    assign misaligned = taken & target[1];
`else
    assign misaligned = 1'b0;
`endif

    // The instruction right behind a taken control transfer is on the wrong path.
    assign squashing     = (state_reg == SQUASH);
    assign keep          = valid_in & ~squashing;
    assign redirect_take = keep & taken & ~misaligned;
    assign state_next    = redirect_take ? SQUASH : NORMAL;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg       <= NORMAL;
            valid_out       <= 1'b0;
            reg_write_out   <= 1'b0;
            mem_read_out    <= 1'b0;
            mem_write_out   <= 1'b0;
            result_out      <= 32'h0;
            rs2_out         <= 32'h0;
            rd_out          <= 5'h0;
            redirect        <= 1'b0;
            redirect_pc     <= 32'h0;
            misaligned_trap <= 1'b0;
        end else if (flush) begin
            state_reg       <= NORMAL;
            valid_out       <= 1'b0;
            reg_write_out   <= 1'b0;
            mem_read_out    <= 1'b0;
            mem_write_out   <= 1'b0;
            redirect        <= 1'b0;
            misaligned_trap <= 1'b0;
        end else if (stall) begin
            // Pulses must not be replayed while the stage is held.
            redirect        <= 1'b0;
            misaligned_trap <= 1'b0;
        end else begin
            state_reg       <= state_next;
            valid_out       <= keep;
            reg_write_out   <= keep & reg_write_in & ~misaligned;
            mem_read_out    <= keep & mem_read_in;
            mem_write_out   <= keep & mem_write_in;
            result_out      <= (jal_in | jalr_in) ? link : alu_result;
            rs2_out         <= rs2_in;
            rd_out          <= rd_in;
            redirect        <= redirect_take;
            redirect_pc     <= target;
            misaligned_trap <= keep & misaligned;
        end
    end

endmodule

// File: tb/tb_estagio_ex_mem.sv
// Self-checking bench for estagio_ex_mem; honours MISALIGN_TRAP_EN when defined.
module tb_estagio_ex_mem;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] alu_result, pc_in, imm_in, rs2_in;
    logic        zero, less, less_unsigned;
    logic [4:0]  rd_in;
    logic [2:0]  funct3_in;
    logic        valid_in, branch_in, jal_in, jalr_in, reg_write_in, mem_read_in, mem_write_in;
    logic        stall, flush;
    logic        valid_out, reg_write_out, mem_read_out, mem_write_out, redirect, misaligned_trap;
    logic [31:0] result_out, rs2_out, redirect_pc;
    logic [4:0]  rd_out;

    always #5 clk = ~clk;

    estagio_ex_mem dut (
        .clk(clk), .reset(reset), .alu_result(alu_result), .zero(zero), .less(less),
        .less_unsigned(less_unsigned), .pc_in(pc_in), .imm_in(imm_in), .rs2_in(rs2_in),
        .rd_in(rd_in), .funct3_in(funct3_in), .valid_in(valid_in), .branch_in(branch_in),
        .jal_in(jal_in), .jalr_in(jalr_in), .reg_write_in(reg_write_in),
        .mem_read_in(mem_read_in), .mem_write_in(mem_write_in), .stall(stall), .flush(flush),
        .valid_out(valid_out), .reg_write_out(reg_write_out), .mem_read_out(mem_read_out),
        .mem_write_out(mem_write_out), .result_out(result_out), .rs2_out(rs2_out),
        .rd_out(rd_out), .redirect(redirect), .redirect_pc(redirect_pc),
        .misaligned_trap(misaligned_trap)
    );

    typedef struct packed {
        logic        valid, rw, mr, mw, redir, trap;
        logic [4:0]  rd;
        logic [31:0] result, rs2, rpc;
    } obs_t;

    obs_t sb_exp[$];
    obs_t sb_mask[$];
    int   checks = 0;
    int   passed = 0;
    bit   model_sq = 1'b0;

    function automatic obs_t sample();
        obs_t o;
        o = {valid_out, reg_write_out, mem_read_out, mem_write_out, redirect, misaligned_trap,
             rd_out, result_out, rs2_out, redirect_pc};
        return o;
    endfunction

    // kind: 0 alu, 1 branch, 2 jal, 3 jalr, 4 load, 5 store; flags = {zero, less, less_unsigned}
    task automatic drive(input logic v, input logic [2:0] kind, input logic [2:0] f3,
                         input logic [31:0] pc, input logic [31:0] imm, input logic [31:0] alu,
                         input logic [4:0] rd, input logic [2:0] flags);
        valid_in      = v;
        branch_in     = (kind == 3'd1);
        jal_in        = (kind == 3'd2);
        jalr_in       = (kind == 3'd3);
        reg_write_in  = (kind == 3'd0) || (kind == 3'd2) || (kind == 3'd3) || (kind == 3'd4);
        mem_read_in   = (kind == 3'd4);
        mem_write_in  = (kind == 3'd5);
        funct3_in     = f3;
        pc_in         = pc;
        imm_in        = imm;
        alu_result    = alu;
        rs2_in        = alu ^ 32'hA5A5_0000;
        rd_in         = rd;
        {zero, less, less_unsigned} = flags;
    endtask

    // Reference model for one accepted instruction; pushes expectation and mask.
    task automatic expect_accept();
        obs_t e, m;
        logic cnd, tk, mis, keep;
        logic [31:0] tgt;
        case (funct3_in)
            3'b000:  cnd = zero;
            3'b001:  cnd = !zero;
            3'b100:  cnd = less;
            3'b101:  cnd = !less;
            3'b110:  cnd = less_unsigned;
            3'b111:  cnd = !less_unsigned;
            default: cnd = 1'b0;
        endcase
        tk  = valid_in && (jal_in || jalr_in || (branch_in && cnd));
        tgt = jalr_in ? (alu_result & 32'hFFFF_FFFE) : (pc_in + imm_in);
`ifdef MISALIGN_TRAP_EN
        mis = tk && tgt[1];
`else
        mis = 1'b0;
`endif
        keep = valid_in && !model_sq;
        e = '0;
        m = '0;
        {m.valid, m.rw, m.mr, m.mw, m.redir, m.trap} = 6'h3F;
        if (keep) begin
            e.valid  = 1'b1;
            e.rw     = reg_write_in && !mis;
            e.mr     = mem_read_in;
            e.mw     = mem_write_in;
            e.rd     = rd_in;
            e.result = (jal_in || jalr_in) ? pc_in + 32'd4 : alu_result;
            e.rs2    = rs2_in;
            e.trap   = mis;
            m.rd     = '1;
            m.result = '1;
            m.rs2    = '1;
            if (tk && !mis) begin
                e.redir = 1'b1;
                e.rpc   = tgt;
                m.rpc   = '1;
            end
        end
        model_sq = keep && tk && !mis;
        sb_exp.push_back(e);
        sb_mask.push_back(m);
    endtask

    task automatic accept_step();
        stall = 1'b0;
        flush = 1'b0;
        expect_accept();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        obs_t o;
        reset = 1'b1;
        drive(1'b1, 3'd2, 3'd0, 32'h10, 32'h8, 32'h1234, 5'd3, 3'b000);
        stall = 1'b0;
        flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        o = sample();
        checks++;
        if (o !== '0) $display("FAIL reset_outputs got=%h exp=0", o);
        else passed++;
        reset = 1'b0;
        drive(1'b0, 3'd0, 3'd0, 32'h0, 32'h0, 32'h0, 5'd0, 3'b000);
    endtask

    task automatic test_branch_conds();
        obs_t o, e, m;
        for (int p = 0; p < 2; p++) begin
            for (int f = 0; f < 8; f++) begin
                drive(1'b1, 3'd1, 3'(f), 32'h1000 + 32'(f * 16), 32'h40, 32'(f + 100), 5'd0,
                      (p == 0) ? 3'b111 : 3'b000);
                accept_step();
                e = sb_exp.pop_front(); m = sb_mask.pop_front(); o = sample();
                checks++;
                if ((o & m) !== (e & m)) $display("FAIL branch_cond f3=%0d p=%0d got=%h exp=%h", f, p, o & m, e & m);
                else passed++;
            end
        end
        // BLTU not taken: no redirect, no squash, result is the ALU value
        drive(1'b1, 3'd0, 3'd0, 32'h0, 32'h0, 32'h0, 5'd1, 3'b000);
        accept_step();
        void'(sb_exp.pop_front()); void'(sb_mask.pop_front());
        drive(1'b1, 3'd1, 3'b110, 32'h500, 32'h80, 32'hDEAD_BEEF, 5'd0, 3'b000);
        accept_step();
        e = sb_exp.pop_front(); m = sb_mask.pop_front(); o = sample();
        checks++;
        if (redirect !== 1'b0 || result_out !== 32'hDEAD_BEEF || (o & m) !== (e & m))
            $display("FAIL bltu_not_taken got=%h exp=%h", o & m, e & m);
        else passed++;
        drive(1'b1, 3'd0, 3'd0, 32'h504, 32'h0, 32'h77, 5'd9, 3'b000);
        accept_step();
        e = sb_exp.pop_front(); m = sb_mask.pop_front(); o = sample();
        checks++;
        if (valid_out !== 1'b1 || (o & m) !== (e & m)) $display("FAIL bltu_no_squash got=%h exp=%h", o & m, e & m);
        else passed++;
    endtask

    task automatic test_redirect();
        obs_t o, e, m;
        drive(1'b1, 3'd1, 3'b000, 32'h100, 32'h20, 32'h0, 5'd0, 3'b100);
        accept_step();
        e = sb_exp.pop_front(); m = sb_mask.pop_front(); o = sample();
        checks++;
        if (redirect !== 1'b1 || redirect_pc !== 32'h120 || valid_out !== 1'b1 || (o & m) !== (e & m))
            $display("FAIL beq_redirect got=%h exp=%h", o & m, e & m);
        else passed++;
        drive(1'b1, 3'd0, 3'd0, 32'h104, 32'h0, 32'h55, 5'd4, 3'b000);
        accept_step();
        e = sb_exp.pop_front(); m = sb_mask.pop_front(); o = sample();
        checks++;
        if (valid_out !== 1'b0 || reg_write_out !== 1'b0 || redirect !== 1'b0 || (o & m) !== (e & m))
            $display("FAIL beq_bubble got=%h exp=%h", o & m, e & m);
        else passed++;
    endtask

    task automatic test_jalr();
        obs_t o, e, m;
        drive(1'b1, 3'd3, 3'd0, 32'h40, 32'h0, 32'h203, 5'd5, 3'b000);
        accept_step();
        e = sb_exp.pop_front(); m = sb_mask.pop_front(); o = sample();
        checks++;
        if (redirect_pc !== 32'h202 || result_out !== 32'h44 || rd_out !== 5'd5 || (o & m) !== (e & m))
            $display("FAIL jalr got=%h exp=%h", o & m, e & m);
        else passed++;
        drive(1'b1, 3'd5, 3'd0, 32'h44, 32'h0, 32'h9, 5'd0, 3'b000);
        accept_step();
        e = sb_exp.pop_front(); m = sb_mask.pop_front(); o = sample();
        checks++;
        if ((o & m) !== (e & m)) $display("FAIL jalr_bubble got=%h exp=%h", o & m, e & m);
        else passed++;
    endtask

    task automatic test_stall_flush();
        obs_t o, e, m, held;
        drive(1'b1, 3'd2, 3'd0, 32'h200, 32'h10, 32'h0, 5'd7, 3'b000);
        accept_step();
        e = sb_exp.pop_front(); m = sb_mask.pop_front(); o = sample();
        checks++;
        if (redirect !== 1'b1 || (o & m) !== (e & m)) $display("FAIL stall_capture got=%h exp=%h", o & m, e & m);
        else passed++;
        held = e;
        held.redir = 1'b0;
        held.trap  = 1'b0;
        m.rpc = '1;
        held.rpc = 32'h210;
        stall = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            o = sample();
            checks++;
            if ((o & m) !== (held & m)) $display("FAIL stall_hold cycle=%0d got=%h exp=%h", c, o & m, held & m);
            else passed++;
        end
        flush = 1'b1;
        @(posedge clk);
        #1;
        o = sample();
        checks++;
        if ({valid_out, reg_write_out, mem_read_out, mem_write_out, redirect, misaligned_trap} !== 6'b0)
            $display("FAIL flush_over_stall got=%h exp=0", o);
        else passed++;
        model_sq = 1'b0;
        // After flush the stage is NORMAL again, so this instruction must not be squashed.
        drive(1'b1, 3'd4, 3'd0, 32'h300, 32'h0, 32'h8000, 5'd12, 3'b000);
        accept_step();
        e = sb_exp.pop_front(); m = sb_mask.pop_front(); o = sample();
        checks++;
        if (valid_out !== 1'b1 || (o & m) !== (e & m)) $display("FAIL flush_normal got=%h exp=%h", o & m, e & m);
        else passed++;
    endtask

    task automatic test_reset_squash();
        obs_t o, e, m;
        drive(1'b1, 3'd1, 3'b001, 32'h600, 32'h24, 32'h0, 5'd0, 3'b000);
        accept_step();
        e = sb_exp.pop_front(); m = sb_mask.pop_front(); o = sample();
        checks++;
        if ((o & m) !== (e & m)) $display("FAIL squash_enter got=%h exp=%h", o & m, e & m);
        else passed++;
        reset = 1'b1;
        #1;
        o = sample();
        checks++;
        if (o !== '0) $display("FAIL reset_in_squash got=%h exp=0", o);
        else passed++;
        model_sq = 1'b0;
        #1;
        reset = 1'b0;
        drive(1'b1, 3'd1, 3'b001, 32'h300, 32'h40, 32'h0, 5'd0, 3'b000);
        accept_step();
        e = sb_exp.pop_front(); m = sb_mask.pop_front(); o = sample();
        checks++;
        if (redirect !== 1'b1 || redirect_pc !== 32'h340 || (o & m) !== (e & m))
            $display("FAIL redirect_after_reset got=%h exp=%h", o & m, e & m);
        else passed++;
        drive(1'b0, 3'd0, 3'd0, 32'h0, 32'h0, 32'h0, 5'd0, 3'b000);
        accept_step();
        void'(sb_exp.pop_front()); void'(sb_mask.pop_front());
    endtask

    task automatic test_misalign();
        obs_t o, e, m;
        drive(1'b1, 3'd2, 3'd0, 32'h100, 32'h2, 32'h0, 5'd8, 3'b000);
        accept_step();
        e = sb_exp.pop_front(); m = sb_mask.pop_front(); o = sample();
        checks++;
`ifdef MISALIGN_TRAP_EN
        if (misaligned_trap !== 1'b1 || redirect !== 1'b0 || reg_write_out !== 1'b0 || (o & m) !== (e & m))
`else
        if (misaligned_trap !== 1'b0 || redirect !== 1'b1 || redirect_pc !== 32'h102 || (o & m) !== (e & m))
`endif
            $display("FAIL jal_misaligned got=%h exp=%h", o & m, e & m);
        else passed++;
        drive(1'b1, 3'd0, 3'd0, 32'h104, 32'h0, 32'h31, 5'd2, 3'b000);
        accept_step();
        e = sb_exp.pop_front(); m = sb_mask.pop_front(); o = sample();
        checks++;
        if ((o & m) !== (e & m)) $display("FAIL misalign_follow got=%h exp=%h", o & m, e & m);
        else passed++;
    endtask

    task automatic test_back_to_back();
        obs_t o, e, m, last_e, last_m;
        last_e = '0;
        last_m = '0;
        for (int i = 0; i < 60; i++) begin
            drive(($urandom % 6) != 0, 3'($urandom % 6), 3'($urandom % 8),
                  $urandom & 32'hFFFF_FFFC, $urandom & 32'h0000_FFFE, $urandom,
                  5'($urandom % 32), 3'($urandom % 8));
            if (i != 0 && ($urandom % 4) == 0) begin
                stall = 1'b1;
                flush = 1'b0;
                @(posedge clk);
                #1;
                e = last_e;
                e.redir = 1'b0;
                e.trap  = 1'b0;
                m = last_m;
            end else begin
                accept_step();
                e = sb_exp.pop_front();
                m = sb_mask.pop_front();
                last_e = e;
                last_m = m;
            end
            o = sample();
            checks++;
            if ((o & m) !== (e & m)) $display("FAIL back_to_back i=%0d got=%h exp=%h", i, o & m, e & m);
            else passed++;
        end
        stall = 1'b0;
    endtask

    initial begin
        test_reset();
        test_branch_conds();
        test_redirect();
        test_jalr();
        test_stall_flush();
        test_reset_squash();
        test_misalign();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/estagio_ex_mem.md
ESTAGIO_EX_MEM -- requirements
Module: estagio_ex_mem

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 reset  input  1  asynchronous, active-high reset.
REQ-003 alu_result  input  32  ULA result; zero, less, less_unsigned  input  1 each  ULA status flags.
REQ-004 pc_in, imm_in  input  32 each  instruction PC and decoded immediate.
REQ-005 rs2_in  input  32  store data; rd_in  input  5  destination register; funct3_in  input  3.
REQ-006 valid_in, branch_in, jal_in, jalr_in, reg_write_in, mem_read_in, mem_write_in  input  1 each  instruction valid and control bits.
REQ-007 stall  input  1  downstream hold; flush  input  1  external kill (trap).
REQ-008 valid_out, reg_write_out, mem_read_out, mem_write_out  output  1 each  registered control.
REQ-009 result_out, rs2_out  output  32 each; rd_out  output  5  registered payload.
REQ-010 redirect  output  1  one-cycle fetch redirect pulse; redirect_pc  output  32  new fetch address.
REQ-011 misaligned_trap  output  1  registered misaligned-target flag.

Function
REQ-012 Branch condition by funct3_in SHALL be: 000 zero; 001 !zero; 100 less; 101 !less; 110 less_unsigned; 111 !less_unsigned; 010/011 never taken.
REQ-013 taken SHALL be valid_in & (jal_in | jalr_in | (branch_in & condition)).
REQ-014 Target SHALL be pc_in+imm_in for branch/jal, and {alu_result[31:1],1'b0} for jalr; 32-bit wrap-around, no overflow detection.
REQ-015 result_out SHALL capture pc_in+4 (mod 2^32) for jal/jalr, else alu_result.
REQ-016 Capture (accept) SHALL occur on an edge with stall=0 and flush=0; latency input-to-output exactly one cycle.
REQ-017 stall=1 SHALL hold every registered output and FSM state unchanged; upstream holds its inputs.
REQ-018 flush=1 SHALL clear valid_out, reg_write_out, mem_read_out, mem_write_out, redirect, misaligned_trap next edge and force state NORMAL; flush overrides stall.
REQ-019 FSM states NORMAL, SQUASH; NORMAL->SQUASH on accept with taken=1; SQUASH->NORMAL on next accept, which SHALL store a bubble (valid and all write/mem controls 0) regardless of valid_in.
REQ-020 In SQUASH an accepted instruction SHALL never assert redirect, even if it would be taken.
REQ-021 redirect SHALL be 1 for exactly the cycle after an accepted taken instruction, then 0 even if stall=1 in that cycle; redirect_pc holds the registered target.
REQ-022 valid_in=0 accepted in NORMAL SHALL produce a bubble and no redirect.

Reset
REQ-023 reset=1 SHALL immediately set all outputs to 0 (32-bit buses to 32'h0) and state to NORMAL, including mid-stall or mid-SQUASH.

Configuration
REQ-024 With MISALIGN_TRAP_EN defined, a taken accepted instruction with target[1]=1 SHALL set misaligned_trap=1 for one cycle, suppress redirect, clear reg_write_out, and not enter SQUASH.
REQ-025 Without MISALIGN_TRAP_EN, misaligned_trap SHALL be constant 0 and target[1] SHALL be ignored.

Structure
REQ-026 Shared package riscv_pkg SHALL hold funct3 branch constants (BEQ, BNE, BLT, BGE, BLTU, BGEU) and the FSM state enum.
REQ-027 Branch condition evaluation (REQ-012) SHALL be a combinational sub-module unidade_branch.

Verification
REQ-028 BEQ, zero=1, pc_in=32'h100, imm_in=32'h20 -> next cycle redirect=1, redirect_pc=32'h120, valid_out=1; following accept emits bubble.
REQ-029 BLTU, less_unsigned=0 -> redirect=0, state stays NORMAL, result_out=alu_result.
REQ-030 JALR, alu_result=32'h203, pc_in=32'h40, rd_in=5 -> redirect_pc=32'h202, result_out=32'h44, rd_out=5.
REQ-031 stall=1 for 3 cycles after capture -> outputs constant, redirect high only first cycle; flush=1 with stall=1 -> valid_out=0 next edge.
REQ-032 reset asserted in SQUASH -> outputs 0 immediately; next valid taken branch redirects normally.
REQ-033 MISALIGN_TRAP_EN: JAL target 32'h102 -> misaligned_trap=1, redirect=0, reg_write_out=0; without macro -> redirect=1, redirect_pc=32'h102.
